// File: rtl/pkt_chan_sched_pkg.sv
// Shared types and constants for the packet channel scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, upr control bit indices, bus and counter
// widths, default level threshold, and small helper functions.
package pkt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FORM = 2'd1,
    WAIT_TX   = 2'd2,
    FLUSH     = 2'd3
  } sched_state_t;

  // upr control word
  localparam int UPR_W    = 8;
  localparam int UPR_EN   = 0;  // grant enable
  localparam int UPR_RATE = 1;  // rate-limit enable

  // bus and counter widths
  localparam int LEV_W   = 9;   // per-channel FIFO level
  localparam int GRANT_W = 8;   // grant_ch output width
  localparam int CNT_W   = 16;  // pkt_cnt / drop_cnt
  localparam int WIN_W   = 32;  // rate window timer

  localparam int AF_THR_DEF = 300;

  // Width of an index into n items (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturating increment for the status counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pkt_chan_sched_if.sv
// Handshake/status bundle between scheduler, FIFO levels, former and transmitter.
// Latency: n/a (wires only).
// Backpressure: none; go/form_start/end_tx are single-cycle pulses.
// Ports: upr (control), lev/full (FIFO status), form_start/end_tx (former and
// transmitter pulses) in; go, grant_ch, fifo_clr, busy, tmo_err, pkt_cnt,
// drop_cnt out of the scheduler.
interface pkt_chan_sched_if #(
  parameter int N_CH = 2
);
  import pkt_sched_pkg::*;

  logic [UPR_W-1:0]        upr;
  logic [N_CH*LEV_W-1:0]   lev;
  logic [N_CH-1:0]         full;
  logic                    form_start;
  logic                    end_tx;

  logic                    go;
  logic [GRANT_W-1:0]      grant_ch;
  logic                    fifo_clr;
  logic                    busy;
  logic                    tmo_err;
  logic [CNT_W-1:0]        pkt_cnt;
  logic [CNT_W-1:0]        drop_cnt;

  // Environment side: drives control, levels and datapath pulses.
  modport master (
    output upr, lev, full, form_start, end_tx,
    input  go, grant_ch, fifo_clr, busy, tmo_err, pkt_cnt, drop_cnt
  );

  // Scheduler side.
  modport slave (
    input  upr, lev, full, form_start, end_tx,
    output go, grant_ch, fifo_clr, busy, tmo_err, pkt_cnt, drop_cnt
  );

endinterface

// File: rtl/pkt_chan_sched_rr_pick.sv
// Round-robin priority picker: first eligible channel scanning i_ptr, i_ptr+1, ... mod N_CH.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_elig (eligible vector), i_ptr (scan start, < N_CH) in;
//        o_vld (any eligible), o_idx (winning channel) out.
module rr_pick
  import pkt_sched_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic [N_CH-1:0]         i_elig,
  input  logic [idx_w(N_CH)-1:0]  i_ptr,
  output logic                    o_vld,
  output logic [idx_w(N_CH)-1:0]  o_idx
);

  localparam int PTR_W = idx_w(N_CH);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Walk offsets from the far end back to zero so the smallest offset
  // from i_ptr is the last one to assign, i.e. it wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_CH)) begin
        w_sum = w_sum - (PTR_W+1)'(N_CH);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_elig[w_idx]) begin
        o_vld = 1'b1;
        o_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/pkt_chan_sched.sv
// Round-robin channel scheduler for the packet former: grants one channel, tracks the
// packet through form_start and end_tx, flushes FIFOs on overflow or watchdog expiry.
// Latency: eligible in IDLE at cycle t -> go at t+1; FLUSH lasts exactly one cycle.
// Backpressure: no new grant while a packet is in flight, when upr[0]=0, or while throttled.
// Ports: clk, rst (synchronous, active high); sched (slave modport) carries upr, lev,
// full, form_start, end_tx in and go, grant_ch, fifo_clr, busy, tmo_err, pkt_cnt, drop_cnt out.
module pkt_chan_sched
  import pkt_sched_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int AF_THR    = AF_THR_DEF,
  parameter int BURST_MAX = 50,
  parameter int WINDOW    = 20000000,
  parameter int TMO       = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  pkt_chan_sched_if.slave       sched
);

  localparam int PTR_W   = idx_w(N_CH);
  localparam int WD_W    = idx_w(TMO);
  localparam int BURST_W = $clog2(BURST_MAX + 1);

  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TMO - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

  // state and registered outputs
  sched_state_t        r_state;
  sched_state_t        w_state_nxt;
  logic                r_go;
  logic [GRANT_W-1:0]  r_grant;
  logic                r_tmo;
  logic                r_post_rst;
  logic [CNT_W-1:0]    r_pkt_cnt;
  logic [CNT_W-1:0]    r_drop_cnt;

  // scheduling bookkeeping
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [BURST_W-1:0]  r_burst;
  logic [WIN_W-1:0]    r_win;
  logic [WD_W-1:0]     r_wd;

  // combinational decisions
  logic [N_CH-1:0]     w_elig;
  logic                w_any_full;
  logic                w_throttled;
  logic                w_pick_vld;
  logic [PTR_W-1:0]    w_pick_idx;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic                w_grant;
  logic                w_done;
  logic                w_ovf;
  logic                w_tmo;
  logic                w_win_wrap;
  logic                w_unused_upr;

  // Only the two low control bits carry meaning.
  assign w_unused_upr = ^sched.upr[UPR_W-1:2];

  // A channel qualifies when strictly above threshold and not already full.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_elig[i] = (sched.lev[i*LEV_W +: LEV_W] > LEV_W'(AF_THR)) && !sched.full[i];
    end
  end

  assign w_any_full  = |sched.full;
  assign w_throttled = sched.upr[UPR_RATE] && (r_burst >= BURST_LIM);
  assign w_win_wrap  = (r_win == WIN_LAST);

  rr_pick #(
    .N_CH (N_CH)
  ) u_rr_pick (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  assign w_ptr_nxt = (w_pick_idx == PTR_W'(N_CH - 1)) ? '0 : w_pick_idx + PTR_W'(1);

  // Next-state logic. Overflow outranks completion and watchdog, but a
  // completion seen in the same cycle is still counted (w_done is raised
  // independently of which transition is taken). Completion outranks an
  // expiring watchdog: the packet made it out.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_ovf       = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_full) begin
          w_ovf       = 1'b1;
          w_state_nxt = FLUSH;
        end else if (sched.upr[UPR_EN] && !w_throttled && w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = WAIT_FORM;
        end
      end
      WAIT_FORM, WAIT_TX: begin
        // While still waiting for the former, end_tx alone is meaningless;
        // together with form_start it means the whole packet went out.
        w_done = (r_state == WAIT_TX) ? sched.end_tx
                                      : (sched.form_start && sched.end_tx);
        if (w_any_full) begin
          w_ovf       = 1'b1;
          w_state_nxt = FLUSH;
        end else if (w_done) begin
          w_state_nxt = IDLE;
        end else if (r_wd == WD_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = FLUSH;
        end else if ((r_state == WAIT_FORM) && sched.form_start) begin
          w_state_nxt = WAIT_TX;
        end
      end
      FLUSH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_go       <= 1'b0;
      r_grant    <= '0;
      r_tmo      <= 1'b0;
      r_post_rst <= 1'b1;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_rr_ptr   <= '0;
      r_burst    <= '0;
      r_win      <= '0;
      r_wd       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_go       <= w_grant;
      r_tmo      <= w_tmo;
      r_post_rst <= 1'b0;

      if (w_grant) begin
        r_grant  <= GRANT_W'(w_pick_idx);
        r_rr_ptr <= w_ptr_nxt;
      end

      if (w_grant) begin
        r_wd <= '0;
      end else if ((r_state == WAIT_FORM) || (r_state == WAIT_TX)) begin
        r_wd <= r_wd + WD_W'(1);
      end

      if (w_done) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end

      if (w_ovf) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end

      // Free-running rate window; a completion landing on the wrap cycle
      // opens the new window with one packet already counted.
      r_win <= w_win_wrap ? '0 : r_win + WIN_W'(1);
      if (w_win_wrap) begin
        r_burst <= w_done ? BURST_W'(1) : '0;
      end else if (w_done && (r_burst < BURST_LIM)) begin
        r_burst <= r_burst + BURST_W'(1);
      end
    end
  end

  // fifo_clr covers the reset cycle itself (via rst), the first cycle after
  // it (r_post_rst) and the single FLUSH cycle.
  assign sched.go       = r_go;
  assign sched.grant_ch = r_grant;
  assign sched.fifo_clr = rst || r_post_rst || (r_state == FLUSH);
  assign sched.busy     = (r_state != IDLE);
  assign sched.tmo_err  = r_tmo;
  assign sched.pkt_cnt  = r_pkt_cnt;
  assign sched.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pkt_chan_sched.sv
// Directed bench for pkt_chan_sched with hand-computed expectations.
// Instance uses TMO=100, BURST_MAX=3, WINDOW=1000 so watchdog and throttle cases stay short.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_pkt_chan_sched;

  localparam int N_CH = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   g;
  int   cnt;
  int   n;

  always #5 clk = ~clk;

  pkt_chan_sched_if #(.N_CH(N_CH)) sched_if ();

  pkt_chan_sched #(
    .N_CH      (N_CH),
    .AF_THR    (300),
    .BURST_MAX (3),
    .WINDOW    (1000),
    .TMO       (100)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (sched_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_lev(input int ch, input logic [8:0] v);
    sched_if.lev[ch*9 +: 9] = v;
  endtask

  // One reset cycle; returns in the first cycle after reset with cyc = 0.
  task automatic do_reset();
    rst = 1'b1;
    sched_if.form_start = 1'b0;
    sched_if.end_tx     = 1'b0;
    sched_if.full       = '0;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Advance until go is seen (at most max cycles); g_cyc = cycle of go.
  task automatic wait_go(input string tag, input int max, output int g_cyc);
    int k;
    k = 0;
    while (!sched_if.go && k < max) begin
      step();
      k++;
    end
    g_cyc = cyc;
    chk(tag, 32'(sched_if.go), 32'd1);
  endtask

  // Called in the go cycle g: form_start at g+5, end_tx at g+25, returns at g+26 (IDLE).
  task automatic run_pkt(input string tag);
    step();
    chk({tag, "_go_1cyc"}, 32'(sched_if.go), 32'd0);
    chk({tag, "_busy"}, 32'(sched_if.busy), 32'd1);
    repeat (4) step();
    sched_if.form_start = 1'b1;
    step();
    sched_if.form_start = 1'b0;
    repeat (19) step();
    sched_if.end_tx = 1'b1;
    step();
    sched_if.end_tx = 1'b0;
    chk({tag, "_idle"}, 32'(sched_if.busy), 32'd0);
  endtask

  task automatic count_go(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      if (sched_if.go) c++;
      step();
    end
  endtask

  initial begin
    // ---- reset state ----
    rst = 1'b1;
    sched_if.upr        = 8'h00;
    sched_if.lev        = '0;
    sched_if.full       = '0;
    sched_if.form_start = 1'b0;
    sched_if.end_tx     = 1'b0;
    #1;
    chk("rst_clr_during", 32'(sched_if.fifo_clr), 32'd1);
    step();
    rst = 1'b0;
    cyc = 0;
    chk("rst_go",       32'(sched_if.go),       32'd0);
    chk("rst_grant",    32'(sched_if.grant_ch), 32'd0);
    chk("rst_busy",     32'(sched_if.busy),     32'd0);
    chk("rst_tmo",      32'(sched_if.tmo_err),  32'd0);
    chk("rst_pkt_cnt",  32'(sched_if.pkt_cnt),  32'd0);
    chk("rst_drop_cnt", 32'(sched_if.drop_cnt), 32'd0);
    chk("rst_clr_after", 32'(sched_if.fifo_clr), 32'd1);
    step();
    chk("rst_clr_end",  32'(sched_if.fifo_clr), 32'd0);

    // ---- round robin: 0,1,0,1 ----
    set_lev(0, 9'd301);
    set_lev(1, 9'd301);
    sched_if.upr = 8'h01;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      wait_go("rr_go", 100, g);
      chk("rr_grant", 32'(sched_if.grant_ch), 32'(p % 2));
      run_pkt("rr");
    end
    chk("rr_pkt_cnt", 32'(sched_if.pkt_cnt), 32'd4);

    // ---- threshold boundary ----
    set_lev(0, 9'd300);
    set_lev(1, 9'd0);
    do_reset();
    count_go(20, cnt);
    chk("thr_no_go_at_300", 32'(cnt), 32'd0);
    set_lev(0, 9'd301);
    chk("thr_go_same_cycle", 32'(sched_if.go), 32'd0);
    step();
    chk("thr_go_next_cycle", 32'(sched_if.go), 32'd1);
    chk("thr_grant", 32'(sched_if.grant_ch), 32'd0);
    set_lev(0, 9'd0);
    run_pkt("thr");

    // ---- overflow together with end_tx in WAIT_TX ----
    set_lev(0, 9'd301);
    do_reset();
    wait_go("ovf_go", 20, g);
    set_lev(0, 9'd0);
    repeat (5) step();
    sched_if.form_start = 1'b1;
    step();
    sched_if.form_start = 1'b0;
    repeat (3) step();
    sched_if.end_tx = 1'b1;
    sched_if.full   = 2'b10;
    chk("ovf_clr_before", 32'(sched_if.fifo_clr), 32'd0);
    step();
    sched_if.end_tx = 1'b0;
    sched_if.full   = '0;
    chk("ovf_clr",      32'(sched_if.fifo_clr), 32'd1);
    chk("ovf_drop_cnt", 32'(sched_if.drop_cnt), 32'd1);
    chk("ovf_pkt_cnt",  32'(sched_if.pkt_cnt),  32'd1);
    chk("ovf_tmo",      32'(sched_if.tmo_err),  32'd0);
    step();
    chk("ovf_clr_1cyc", 32'(sched_if.fifo_clr), 32'd0);
    chk("ovf_idle",     32'(sched_if.busy),     32'd0);

    // ---- watchdog: no form_start after go ----
    set_lev(0, 9'd301);
    do_reset();
    wait_go("wd_go", 20, g);
    set_lev(0, 9'd0);
    n = 0;
    while (!sched_if.tmo_err && n < 150) begin
      step();
      n++;
    end
    chk("wd_tmo_seen", 32'(sched_if.tmo_err), 32'd1);
    chk("wd_delay",    32'(cyc - g), 32'd100);
    chk("wd_clr",      32'(sched_if.fifo_clr), 32'd1);
    step();
    chk("wd_tmo_1cyc", 32'(sched_if.tmo_err), 32'd0);
    chk("wd_clr_1cyc", 32'(sched_if.fifo_clr), 32'd0);
    chk("wd_idle",     32'(sched_if.busy), 32'd0);

    // ---- throttle on: 3 packets, stall until window wrap (go at 1001) ----
    set_lev(0, 9'd301);
    set_lev(1, 9'd301);
    sched_if.upr = 8'h03;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      wait_go("thro_go", 100, g);
      chk("thro_go_cyc", 32'(g), 32'(1 + 27 * p));
      run_pkt("thro");
    end
    wait_go("thro_resume", 1200, g);
    chk("thro_resume_cyc", 32'(g), 32'd1001);

    // ---- throttle off: same stimulus, 4th go right away at 82 ----
    sched_if.upr = 8'h01;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      wait_go("nothro_go", 100, g);
      run_pkt("nothro");
    end
    wait_go("nothro_4th", 100, g);
    chk("nothro_4th_cyc", 32'(g), 32'd82);

    // ---- reset during WAIT_TX ----
    set_lev(0, 9'd0);
    set_lev(1, 9'd301);
    do_reset();
    wait_go("rmid_go1", 20, g);
    chk("rmid_grant_pre", 32'(sched_if.grant_ch), 32'd1);
    run_pkt("rmid1");
    wait_go("rmid_go2", 20, g);
    repeat (5) step();
    sched_if.form_start = 1'b1;
    step();
    sched_if.form_start = 1'b0;
    repeat (3) step();
    chk("rmid_busy_pre", 32'(sched_if.busy), 32'd1);
    rst = 1'b1;
    sched_if.upr = 8'h00;
    #1;
    chk("rmid_clr_during", 32'(sched_if.fifo_clr), 32'd1);
    step();
    rst = 1'b0;
    cyc = 0;
    chk("rmid_go",       32'(sched_if.go),       32'd0);
    chk("rmid_grant",    32'(sched_if.grant_ch), 32'd0);
    chk("rmid_busy",     32'(sched_if.busy),     32'd0);
    chk("rmid_tmo",      32'(sched_if.tmo_err),  32'd0);
    chk("rmid_pkt_cnt",  32'(sched_if.pkt_cnt),  32'd0);
    chk("rmid_drop_cnt", 32'(sched_if.drop_cnt), 32'd0);
    chk("rmid_clr_after", 32'(sched_if.fifo_clr), 32'd1);
    step();
    chk("rmid_clr_end",  32'(sched_if.fifo_clr), 32'd0);

    // ---- enable dropped mid-packet: packet completes, no further grants ----
    sched_if.upr = 8'h01;
    wait_go("en_go", 20, g);
    sched_if.upr = 8'h00;
    run_pkt("en");
    chk("en_pkt_cnt", 32'(sched_if.pkt_cnt), 32'd1);
    count_go(50, cnt);
    chk("en_no_more_go", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_chan_sched.md
Name: pkt_chan_sched

Overview:
- Round-robin scheduler for the packet-forming datapath, which drains one of N_CH sample FIFOs into the shared 32-bit buffer RAM, computes the checksum and pulses `start` to the transmitter.
- Decides which channel the former serves next and grants it.
- Tracks each packet through former start and transmitter `end_tx`.
- Handles FIFO overflow flush, watchdog timeout and packet-rate throttling.
- Sits between the FIFO level outputs and the packet former / transmitter handshake.

Parameters:
- N_CH, 2, number of requesting channels (1..8).
- AF_THR, 300, level threshold; a channel is eligible when lev > AF_THR.
- BURST_MAX, 50, maximum packets per rate window when throttling is enabled.
- WINDOW, 20000000, rate window length in clk cycles.
- TMO, 1000000, watchdog cycles allowed from `go` to `end_tx`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- upr  in  8  control: bit0 = grant enable, bit1 = rate-limit enable, others ignored
- lev  in  N_CH*9  packed FIFO fill levels, channel i at [9i+8:9i]
- full  in  N_CH  FIFO full flags
- form_start  in  1  former's start pulse (buffer ready, checksum valid)
- end_tx  in  1  transmitter done pulse
- go  out  1  one-cycle grant pulse to former
- grant_ch  out  8  granted channel number, stable from `go` until return to IDLE
- fifo_clr  out  1  flush all FIFOs, one-cycle pulse
- busy  out  1  high in any state except IDLE
- tmo_err  out  1  one-cycle pulse on watchdog expiry
- pkt_cnt  out  16  completed packets, wraps
- drop_cnt  out  16  overflow flush events, saturates at FFFF

Behaviour:
- Reset values:
  - State = IDLE; go=0, grant_ch=0, busy=0, tmo_err=0.
  - fifo_clr=1 during the reset cycle and the first cycle after reset.
  - pkt_cnt=0, drop_cnt=0; rr_ptr=0, burst_cnt=0, window timer=0, watchdog=0.
  - Reset mid-packet aborts without completing.
- Eligibility for channel i: lev_i > AF_THR and full_i=0.
- Throttled when upr[1]=1 and burst_cnt >= BURST_MAX.
- Winner: the first eligible channel scanning rr_ptr, rr_ptr+1, … mod N_CH.
- State IDLE:
  - Condition: upr[0]=1, not throttled, winner exists.
  - Action: go=1 next cycle, grant_ch=winner, rr_ptr=(winner+1) mod N_CH, watchdog=0, goto WAIT_FORM.
  - Latency is eligible at cycle t, go at t+1.
- State WAIT_FORM:
  - On form_start, goto WAIT_TX.
  - If form_start and end_tx arrive in the same cycle, treat the packet as complete (see WAIT_TX).
- State WAIT_TX:
  - On end_tx: pkt_cnt+1, burst_cnt+1, goto IDLE.
- Watchdog:
  - Counts every cycle in WAIT_FORM and WAIT_TX.
  - On reaching TMO-1: tmo_err pulse, goto FLUSH.
- State FLUSH:
  - fifo_clr=1 for exactly one cycle, then IDLE; grant_ch held until IDLE.
- Overflow:
  - Any full bit in IDLE, WAIT_FORM or WAIT_TX gives drop_cnt+1 (saturating) and goto FLUSH.
  - Overflow takes priority over end_tx and watchdog in the same cycle.
  - end_tx in that same cycle still increments pkt_cnt.
- upr[0] deassert: no new grants; an in-flight packet still runs to completion.
- Stray pulses: form_start or end_tx in IDLE or FLUSH are ignored.
- Rate window:
  - Free-running timer 0..WINDOW-1; burst_cnt clears on wrap.
  - Wrap and completion in the same cycle gives burst_cnt=1.
  - burst_cnt saturates at BURST_MAX.
  - With upr[1]=0, burst_cnt still counts but does not block.
- Widths:
  - Window timer is 32 bit; watchdog is $clog2(TMO) bits.
  - lev comparison is unsigned 9 bit.

Decomposition:
- Shared package pkt_sched_pkg holds:
  - State encoding IDLE/WAIT_FORM/WAIT_TX/FLUSH.
  - upr bit indices UPR_EN=0, UPR_RATE=1.
  - Counter widths and the default AF_THR.
- One sub-module, rr_pick:
  - Combinational N_CH round-robin priority picker.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: valid and winner index.

Test Plan:
- Round-robin: lev0=lev1=301 continuously, upr=01; answer each go with form_start after 5 cycles and end_tx after 20. Required: grant_ch sequence 0,1,0,1; pkt_cnt=4 after 4 packets.
- Threshold boundary: lev0=300, lev1=0, then lev0=301. Required: no go while 300; go with grant_ch=0 exactly one cycle after lev0=301 is sampled in IDLE.
- Overflow: full1=1 during WAIT_TX together with end_tx. Required: fifo_clr is a one-cycle pulse, drop_cnt=1, pkt_cnt+1, then IDLE with busy=0.
- Watchdog (TMO=100): go, then no form_start. Required: tmo_err pulse 100 cycles after go, then fifo_clr pulse, then IDLE.
- Throttle (BURST_MAX=3, WINDOW=1000, upr=03, both channels eligible): required 3 packets, then no go until window wrap, then grants resume. With upr=01 the same stimulus gives no stall.
- Reset and enable: rst during WAIT_TX gives all outputs at reset values and fifo_clr for 2 cycles. upr[0]=0 mid-packet lets the packet complete, then no further go.
